// File: rtl/mem_access_stage.sv
// Memory-access stage: runs loads/stores against data memory over a
// req/ack handshake and registers the MEM/WB write-back bundle.
module mem_access_stage #(
   parameter int DATA_W  = 16,
   parameter int REG_AW  = 3,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [DATA_W-1:0] in_store_data,
   input  logic [REG_AW-1:0] in_wb_reg,
   input  logic              in_mem_read,
   input  logic              in_mem_write,
   input  logic              in_reg_write,
   output logic              stall_o,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [REG_AW-1:0] wb_reg,
   output logic [DATA_W-1:0] wb_data,
   output logic              err_o,
   output logic [15:0]       ld_cnt,
   output logic [15:0]       st_cnt
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t            state;
   state_t            nextState;
   logic              memOp;
   logic              timeoutHit;
   logic [REG_AW-1:0] capReg;
   logic              capRegWrite;
   logic              abortFlag;
   logic [DATA_W-1:0] rdataLat;
   logic [TO_W-1:0]   toCnt;

   assign memOp = in_valid & (in_mem_read | in_mem_write);

   // An ack in the expiry cycle wins over the timeout.
   assign timeoutHit = !dmem_ack && (toCnt == TO_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE:    if (memOp) nextState = REQ;
         REQ:     if (dmem_ack || timeoutHit) nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      stall_o = ((state == IDLE) && memOp) || (state == REQ);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dmem_req    <= 1'b0;
         dmem_we     <= 1'b0;
         dmem_addr   <= '0;
         dmem_wdata  <= '0;
         wb_valid    <= 1'b0;
         wb_we       <= 1'b0;
         wb_reg      <= '0;
         wb_data     <= '0;
         err_o       <= 1'b0;
         ld_cnt      <= '0;
         st_cnt      <= '0;
         capReg      <= '0;
         capRegWrite <= 1'b0;
         abortFlag   <= 1'b0;
         rdataLat    <= '0;
         toCnt       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (memOp) begin
                  dmem_req    <= 1'b1;
                  dmem_we     <= in_mem_write;
                  dmem_addr   <= in_alu;
                  dmem_wdata  <= in_store_data;
                  capReg      <= in_wb_reg;
                  capRegWrite <= in_reg_write;
                  abortFlag   <= 1'b0;
                  toCnt       <= '0;
                  wb_valid    <= 1'b0;
                  wb_we       <= 1'b0;
               end else begin
                  wb_valid <= in_valid;
                  wb_reg   <= in_wb_reg;
                  wb_data  <= in_alu;
                  wb_we    <= in_valid & in_reg_write
                              & (in_wb_reg != '0);
               end
            end
            REQ: begin
               wb_valid <= 1'b0;
               wb_we    <= 1'b0;
               if (dmem_ack) begin
                  rdataLat <= dmem_rdata;
                  dmem_req <= 1'b0;
               end else if (timeoutHit) begin
                  dmem_req  <= 1'b0;
                  err_o     <= 1'b1;
                  abortFlag <= 1'b1;
               end else begin
                  toCnt <= toCnt + 1'b1;
               end
            end
            DONE: begin
               wb_valid <= 1'b1;
               wb_reg   <= capReg;
               if (abortFlag) begin
                  wb_we   <= 1'b0;
                  wb_data <= '0;
               end else if (dmem_we) begin
                  wb_we   <= 1'b0;
                  wb_data <= dmem_addr;
                  st_cnt  <= st_cnt + 16'd1;
               end else begin
                  wb_we   <= capRegWrite & (capReg != '0);
                  wb_data <= rdataLat;
                  ld_cnt  <= ld_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage of the 16-bit pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its ALU result, store data, destination register and load/store/reg-write controls.
- It runs load/store transactions against the data memory over a req/ack handshake and stalls the upstream pipeline while a transaction is outstanding.
- It registers the write-back result into the MEM/WB output register that feeds the register file and the forwarding logic.

Parameters:
- DATA_W, 16, width of data path and memory address
- REG_AW, 3, destination register index width
- TIMEOUT, 255, maximum cycles waiting for dmem_ack before abort
- TO_W, 8, width of timeout counter (must hold TIMEOUT)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  EX/MEM register holds a valid instruction
- in_alu  in  DATA_W  ALU result; memory address for loads/stores
- in_store_data  in  DATA_W  store data
- in_wb_reg  in  REG_AW  destination register
- in_mem_read  in  1  load
- in_mem_write  in  1  store
- in_reg_write  in  1  instruction writes a register
- stall_o  out  1  hold EX/MEM and all earlier stages this cycle
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  DATA_W  word address
- dmem_wdata  out  DATA_W  write data
- dmem_ack  in  1  transaction complete; rdata valid on loads
- dmem_rdata  in  DATA_W  read data
- wb_valid  out  1  MEM/WB holds a valid instruction
- wb_we  out  1  register-file write enable
- wb_reg  out  REG_AW  register-file write index
- wb_data  out  DATA_W  write-back data
- err_o  out  1  sticky memory-timeout flag
- ld_cnt  out  16  completed loads, wraps at 16'hFFFF→0
- st_cnt  out  16  completed stores, wraps

Behaviour:
- Reset (async, immediate): state IDLE; dmem_req, dmem_we, wb_valid, wb_we, err_o = 0; dmem_addr, dmem_wdata, wb_data, ld_cnt, st_cnt = 0; wb_reg = 0. Reset during REQ drops dmem_req at once and abandons the transaction without writeback.
- mem_op = in_valid & (in_mem_read | in_mem_write).
- If both read and write are set, the instruction is a store; the load is ignored.
- FSM states are IDLE, REQ and DONE.
  - IDLE, no mem_op: pass-through. At the next edge, wb_valid=in_valid, wb_reg=in_wb_reg, wb_data=in_alu, wb_we=in_valid & in_reg_write & (in_wb_reg!=0). Latency 1 cycle, no stall.
  - IDLE, mem_op: capture address, wdata, we, wb_reg and reg_write; go to REQ with dmem_req=1 registered. wb_valid=0 is loaded (bubble).
  - REQ: dmem_req, dmem_we, dmem_addr and dmem_wdata stay stable until ack. On dmem_ack, latch dmem_rdata, drop dmem_req next edge and go to DONE. The timeout counter clears on REQ entry and increments each cycle without ack. If count reaches TIMEOUT with no ack, drop req, set err_o, go to DONE with abort flag set.
  - DONE: the instruction is consumed this cycle.
    - MEM/WB loads wb_valid=1 and wb_reg=captured reg.
    - Load: wb_data=latched rdata, wb_we=reg_write & (reg!=0).
    - Store: wb_data=address, wb_we=0.
    - Abort: wb_we=0, wb_data=0.
    - Counters: ld_cnt or st_cnt += 1 on a non-aborted completion.
    - Next state IDLE.
- stall_o is combinational: stall_o = (IDLE & mem_op) | REQ. It is 0 in DONE.
- Minimum memory-op latency is 3 cycles: IDLE accept, REQ with same-cycle ack, DONE. Each extra cycle of ack delay adds 1 cycle.
- The instruction in EX/MEM must be unchanged while stall_o=1. This stage does not re-check it.
- dmem_ack in IDLE or DONE is ignored (spurious) and does not affect state.
- Ack arriving in the same cycle as timeout expiry counts as success; err_o is not set.
- Back-to-back memory ops: the second op is accepted in the IDLE cycle right after DONE.
- err_o is sticky until rst.

Test Plan:
- ALU op, in_alu=16'h1234, reg 3, reg_write=1 → next cycle wb_valid=1, wb_we=1, wb_reg=3, wb_data=16'h1234; stall_o never 1.
- Load from 16'h0040, ack on 3rd REQ cycle with rdata=16'hBEEF → stall_o high for 4 cycles; dmem_addr=16'h0040 stable; DONE writes wb_data=16'hBEEF to reg 5; ld_cnt=1.
- Store 16'hA5A5 to 16'h0010, ack in the first REQ cycle → dmem_we=1, dmem_wdata=16'hA5A5; wb_we=0; st_cnt=1; stall_o high exactly 2 cycles.
- Load, ack never asserted, TIMEOUT=4 → req drops after 4 REQ cycles; err_o=1 and stays 1; wb_we=0; ld_cnt unchanged.
- Reset asserted mid-REQ → dmem_req=0 immediately; all outputs at reset values; after release, an ALU op passes normally.
- Load to reg 0, and a read+write-flagged op → reg 0: wb_we=0. Both flags set: dmem_we=1 and st_cnt increments.
